// File: rtl/piso_tx_if.sv
//------------------------------------------------------------------------------
// Module      : piso_tx_if
// Description : Load handshake and serial output bundle for piso_tx.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] d;
  logic             so;
  logic             so_valid;
  logic             done;

  modport master (
    output load_valid,
    output d,
    input  load_ready,
    input  so,
    input  so_valid,
    input  done
  );

  modport slave (
    input  load_valid,
    input  d,
    output load_ready,
    output so,
    output so_valid,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/piso_tx.sv
//------------------------------------------------------------------------------
// Module      : piso_tx
// Description : Parallel-in serial-out transmitter with gapless word streaming.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  wire           clk,
  input  wire           rst,
  piso_tx_if.slave      bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_head;
  logic [WIDTH-1:0] w_shifted;
  logic             w_ready;
  logic             w_accept;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_head    = shreg_q[0];
      assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_head    = shreg_q[WIDTH-1];
      assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  // Ready depends only on state and counter, never on load_valid.
  assign w_ready  = (state_q == ST_IDLE) || (cnt_q == '0);
  assign w_accept = bus.load_valid && w_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          shreg_d = bus.d;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = w_shifted;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (w_accept) begin
          shreg_d = bus.d;
          cnt_d   = CW'(WIDTH - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.so         = (state_q == ST_SHIFT) ? w_head : 1'b0;
  assign bus.so_valid   = (state_q == ST_SHIFT);
  assign bus.done       = (state_q == ST_SHIFT) && (cnt_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_piso_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_piso_tx
// Description : Checks three piso_tx configurations against a bit-queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  lv = '0;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0;

  piso_tx_if #(.WIDTH(4)) bus0 ();
  piso_tx_if #(.WIDTH(4)) bus1 ();
  piso_tx_if #(.WIDTH(8)) bus2 ();

  assign bus0.load_valid = lv[0];
  assign bus1.load_valid = lv[1];
  assign bus2.load_valid = lv[2];
  assign bus0.d = d0[3:0];
  assign bus1.d = d1[3:0];
  assign bus2.d = d2[7:0];

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb4 (.clk(clk), .rst(rst), .bus(bus0.slave));
  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb4 (.clk(clk), .rst(rst), .bus(bus1.slave));
  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic [2:0] so_w, sv_w, dn_w, rdy_w;
  assign so_w  = {bus2.so, bus1.so, bus0.so};
  assign sv_w  = {bus2.so_valid, bus1.so_valid, bus0.so_valid};
  assign dn_w  = {bus2.done, bus1.done, bus0.done};
  assign rdy_w = {bus2.load_ready, bus1.load_ready, bus0.load_ready};

  int total = 0;
  int bad   = 0;

  // Model: pend holds the bits still to be sent, in send order from bit 0.
  logic [63:0] pend [3];
  int          cnt  [3];
  logic        chk_en = 1'b0;

  logic [63:0] log_bits [3];
  int          log_n    [3];
  int          ndone    [3];

  function automatic int wd(int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic logic [31:0] dsel(int k);
    return (k == 0) ? d0 : (k == 1) ? d1 : d2;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      automatic logic [63:0] p = pend[k];
      automatic int          c = cnt[k];
      automatic logic        acc;
      automatic logic [31:0] dv = dsel(k);
      if (rst) begin
        p = '0;
        c = 0;
      end else begin
        acc = lv[k] && (c <= 1);
        if (c > 0) begin
          p = p >> 1;
          c = c - 1;
        end
        if (acc) begin
          for (int i = 0; i < wd(k); i++)
            p[c + i] = (k == 1) ? dv[i] : dv[wd(k) - 1 - i];
          c = c + wd(k);
        end
      end
      pend[k] <= p;
      cnt[k]  <= c;
    end
    if (rst) chk_en <= 1'b1;
  end

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%b want=%b", nm, k, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("so",         k, so_w[k],  (cnt[k] > 0) ? pend[k][0] : 1'b0);
        chk("so_valid",   k, sv_w[k],  cnt[k] > 0);
        chk("done",       k, dn_w[k],  cnt[k] == 1);
        chk("load_ready", k, rdy_w[k], cnt[k] <= 1);
        if (sv_w[k] === 1'b1) begin
          log_bits[k] = {log_bits[k][62:0], so_w[k]};
          log_n[k]++;
        end
        if (dn_w[k] === 1'b1) ndone[k]++;
      end
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) begin
      log_bits[k] = '0;
      log_n[k]    = 0;
      ndone[k]    = 0;
    end
  endtask

  task automatic set_d(input int k, input logic [31:0] v);
    if (k == 0) d0 = v;
    else if (k == 1) d1 = v;
    else d2 = v;
  endtask

  task automatic send(input int k, input logic [31:0] v);
    set_d(k, v);
    lv[k] = 1'b1;
    @(posedge clk); #1;
    lv[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = '0;
      cnt[k]  = 0;
    end
    clear_logs();
    idle(2);
    rst = 1'b0;
    lit("reset_ready", rdy_w, 3'b111);
    lit("reset_valid", sv_w, 3'b000);
    lit("reset_so",    so_w, 3'b000);

    // MSB-first single word
    clear_logs();
    send(0, 32'b1011);
    idle(5);
    lit("msb_bits", log_bits[0], 64'b1011);
    lit("msb_len",  log_n[0], 4);
    lit("msb_done", ndone[0], 1);

    // LSB-first single word
    clear_logs();
    send(1, 32'b1011);
    idle(5);
    lit("lsb_bits", log_bits[1], 64'b1101);
    lit("lsb_done", ndone[1], 1);

    // Back-to-back words, second accepted on the last-bit edge
    clear_logs();
    send(0, 32'b1100);
    idle(3);
    send(0, 32'b0011);
    idle(6);
    lit("b2b_bits", log_bits[0], 64'b11000011);
    lit("b2b_len",  log_n[0], 8);
    lit("b2b_done", ndone[0], 2);

    // Load requests while busy are ignored until the last bit
    clear_logs();
    send(0, 32'b1010);
    set_d(0, 32'b0101);
    lv[0] = 1'b1;
    idle(4);
    lv[0] = 1'b0;
    idle(5);
    lit("busy_bits", log_bits[0], 64'b10100101);
    lit("busy_done", ndone[0], 2);

    // Reset mid-word aborts the word
    clear_logs();
    send(0, 32'b1111);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    lit("abort_so",    so_w[0], 0);
    lit("abort_valid", sv_w[0], 0);
    lit("abort_done",  dn_w[0], 0);
    lit("abort_ready", rdy_w[0], 1);
    lit("abort_len",   log_n[0], 2);
    clear_logs();
    send(0, 32'b1001);
    idle(5);
    lit("post_rst_bits", log_bits[0], 64'b1001);

    // Eight-bit word
    clear_logs();
    send(2, 32'hA5);
    idle(9);
    lit("w8_bits", log_bits[2], 64'hA5);
    lit("w8_len",  log_n[2], 8);
    lit("w8_done", ndone[2], 1);

    // Streaming: four words with load_valid held high
    clear_logs();
    set_d(1, 32'b0110);
    lv[1] = 1'b1;
    idle(13);
    lv[1] = 1'b0;
    idle(6);
    lit("stream_len",  log_n[1], 16);
    lit("stream_bits", log_bits[1], 64'h6666);
    lit("stream_done", ndone[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter: the sending end of the serial bit stream consumed by the SISO shift-register chain. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on SO, qualified by SO_VALID. It pulses DONE on the final bit. Back-to-back words stream with no idle gap, so SO can drive a SISO SI input directly.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = shift MSB first (D[WIDTH-1] first); 1 = shift LSB first (D[0] first).

- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- LOAD_VALID  input  1  parallel word on D is offered.
- LOAD_READY  output  1  block can accept a word this cycle.
- D  input  WIDTH  parallel data word; sampled only on an accepting edge.
- SO  output  1  serial data out.
- SO_VALID  output  1  SO carries a data bit this cycle.
- DONE  output  1  one-cycle pulse during the last bit of a word.

## Operation
- Reset (RST=1 at a rising edge): state IDLE, shift register cleared, bit counter 0.
  - Outputs after that edge: SO=0, SO_VALID=0, DONE=0, LOAD_READY=1.
- Accept occurs at a rising edge where LOAD_VALID=1 and LOAD_READY=1.
  - D is captured into the internal shift register.
  - The counter loads WIDTH-1.
  - State moves to SHIFT.
- States:
  - IDLE: SO=0, SO_VALID=0, DONE=0, LOAD_READY=1. Accept -> SHIFT; otherwise stay.
  - SHIFT: SO = current head bit (bit WIDTH-1 if LSB_FIRST=0, bit 0 if LSB_FIRST=1); SO_VALID=1.
    - Each edge shifts the register one position toward the head and decrements the counter.
    - While counter > 0: LOAD_READY=0 and DONE=0.
    - Last-bit cycle (counter = 0): DONE=1 and LOAD_READY=1.
    - On the edge ending the last bit: if accept, reload and stay in SHIFT; otherwise go to IDLE.
- LOAD_VALID while LOAD_READY=0 is ignored. D changes mid-word have no effect on SO.
- SO is registered; it never combinationally depends on D or LOAD_VALID.
- RST has priority over accept. Reset mid-word aborts the word immediately; the remaining bits are discarded.
- LOAD_READY is a function of state and counter only. It does not depend on LOAD_VALID, so there are no combinational loops.

## Timing
- Latency: the first bit appears on SO in the cycle immediately after the accepting edge.
- A word occupies exactly WIDTH consecutive SO_VALID cycles.
- Throughput is 1 bit/clock sustained. With LOAD_VALID held high, SO_VALID stays high indefinitely with zero gap cycles between words.
- DONE is high for exactly one cycle per word, coincident with the final bit.
- Minimum spacing between accepts is WIDTH cycles.
- After reset deasserts, the first accept is possible on the first edge with RST=0.
- Counter width: clog2(WIDTH) bits. No arithmetic overflow; the counter never wraps below 0 because reload or IDLE occurs at 0.

## Test plan
All scenarios use WIDTH=4 unless noted; "cycle 1" is the cycle after the accepting edge.
- Basic MSB-first: LSB_FIRST=0, accept D=4'b1011.
  - SO=1,0,1,1 in cycles 1–4; SO_VALID=1 in cycles 1–4 only.
  - DONE=1 in cycle 4 only; LOAD_READY=0 in cycles 1–3.
  - Cycle 5: SO=0, SO_VALID=0.
- LSB-first: LSB_FIRST=1, accept D=4'b1011 -> SO=1,1,0,1 in cycles 1–4; DONE in cycle 4.
- Back-to-back: LSB_FIRST=0, D=4'b1100 accepted, then D=4'b0011 accepted on the last-bit edge.
  - SO=1,1,0,0,0,0,1,1 over 8 contiguous cycles with SO_VALID never dropping.
  - DONE in cycles 4 and 8.
- Busy ignore: accept 4'b1010, then in cycles 1–3 drive LOAD_VALID=1 with D=4'b0101.
  - SO=1,0,1,0.
  - With LOAD_VALID still high in cycle 4, the second word is accepted at the end of cycle 4 and 0,1,0,1 follows.
- Reset mid-word: accept 4'b1111, assert RST in cycle 2.
  - Next cycle: SO=0, SO_VALID=0, DONE=0, LOAD_READY=1.
  - A subsequent accept of 4'b1001 shifts 1,0,0,1 cleanly.
- Width sweep: WIDTH=8, D=8'hA5, LSB_FIRST=0 -> SO=1,0,1,0,0,1,0,1; DONE in cycle 8 only.
